bf_io_uart: RTL and testbench

- io-bus responder that connects the bfcpu `.`/`,` port to a UART serial line, replacing the LED responder on boards with a serial bridge.
- Writes (`.`) queue a byte into a TX FIFO, which is serialised 8N1 on uart_tx.
- Reads (`,`) stall the CPU until a byte has been received on uart_rx, then return it.

---
 rtl/bf_io_uart_pkg.sv | 20 ++
 rtl/bf_uart_tx_fifo.sv | 49 ++++
 rtl/bf_io_uart.sv | 249 ++++++++++++++++++++++++
 tb/tb_bf_io_uart.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_io_uart_pkg.sv
// Shared constants for the bfcpu io-bus UART bridge: io direction encoding
// (same values as the CPU's macros) and the FSM state encodings.
package bf_io_uart_pkg;

  localparam logic DIRECTION_WRITE = 1'b1;
  localparam logic DIRECTION_READ  = 1'b0;

  typedef enum logic {
    BUS_IDLE,
    BUS_DROP
  } bus_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

endpackage

// File: rtl/bf_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO for bytes waiting to be transmitted.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bf_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // A simultaneous push and pop both advance, leaving the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/bf_io_uart.sv
// bfcpu io-bus responder bridging '.' writes to an 8N1 transmitter (via a FIFO)
// and ',' reads to a receiver with a single-byte holding register.
module bf_io_uart
  import bf_io_uart_pkg::*;
#(
  parameter int CLK_HZ   = 24000000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_req,
  input  logic       io_dir,
  input  logic [7:0] io_wdata,
  output logic       io_ack,
  output logic [7:0] io_rdata,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_overrun
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  bus_state_t bus_state;
  ser_state_t tx_state;
  ser_state_t rx_state;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic          wr_accept;
  logic          rd_take;
  logic          tx_pop;
  logic          tx_end;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic          rx_end;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_hold;
  logic          rx_valid;
  logic          rx_ferr;

  assign wr_accept = (bus_state == BUS_IDLE) && io_req && (io_dir == DIRECTION_WRITE) && !fifo_full;
  assign rd_take   = (bus_state == BUS_IDLE) && io_req && (io_dir != DIRECTION_WRITE) && rx_valid;

  bf_uart_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_accept),
    .wdata (io_wdata),
    .pop   (tx_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // DROP holds off new transactions until the CPU releases io_req.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_state <= BUS_IDLE;
      io_ack    <= 1'b0;
      io_rdata  <= 8'h00;
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          io_ack <= 1'b0;
          if (wr_accept) begin
            io_ack    <= 1'b1;
            bus_state <= BUS_DROP;
          end else if (rd_take) begin
            io_rdata  <= rx_hold;
            io_ack    <= 1'b1;
            bus_state <= BUS_DROP;
          end
        end
        BUS_DROP: begin
          io_ack <= 1'b0;
          if (!io_req) begin
            bus_state <= BUS_IDLE;
          end
        end
        default: bus_state <= BUS_IDLE;
      endcase
    end
  end

  assign tx_end = (tx_cnt == DIV_LAST);
  assign tx_pop = !fifo_empty && ((tx_state == SER_IDLE) || ((tx_state == SER_STOP) && tx_end));

  // Popping at the last stop-bit clock chains frames with no idle gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= SER_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        SER_IDLE: begin
          tx_cnt  <= '0;
          uart_tx <= 1'b1;
          if (tx_pop) begin
            tx_shift <= fifo_rdata;
            uart_tx  <= 1'b0;
            tx_state <= SER_START;
          end
        end
        SER_START: begin
          if (tx_end) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_shift[0];
            tx_state <= SER_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        SER_DATA: begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= SER_STOP;
            end else begin
              tx_shift <= tx_shift >> 1;
              uart_tx  <= tx_shift[1];
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        SER_STOP: begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= fifo_rdata;
              uart_tx  <= 1'b0;
              tx_state <= SER_START;
            end else begin
              tx_state <= SER_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= SER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_end = (rx_cnt == DIV_LAST);

  // A load in the same cycle as a bus read wins over the read's clear of
  // rx_valid, and is not an overrun because the old byte was consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state   <= SER_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'h00;
      rx_hold    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      if (rd_take) begin
        rx_valid <= 1'b0;
      end
      case (rx_state)
        SER_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) begin
            rx_state <= SER_START;
          end
        end
        SER_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s2 ? SER_IDLE : SER_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        SER_DATA: begin
          if (rx_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= SER_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        SER_STOP: begin
          if (!rx_end) begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end else if (rx_s2) begin
            if (!rx_ferr) begin
              rx_hold  <= rx_shift;
              rx_valid <= 1'b1;
              if (rx_valid && !rd_take) begin
                rx_overrun <= 1'b1;
              end
            end
            rx_ferr  <= 1'b0;
            rx_cnt   <= '0;
            rx_state <= SER_IDLE;
          end else begin
            rx_ferr <= 1'b1;
          end
        end
        default: rx_state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_io_uart.sv
// Directed bench for bf_io_uart at DIV=10: bus writes are scoreboarded against
// a serial-line decoder, bus reads against bytes driven onto uart_rx.
module tb_bf_io_uart;
  import bf_io_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_req = 1'b0;
  logic       io_dir = DIRECTION_READ;
  logic [7:0] io_wdata = 8'h00;
  logic       io_ack;
  logic [7:0] io_rdata;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic       rx_overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int tx_frames = 0;
  bit mon_en = 1'b1;
  logic [7:0] tx_exp[$];
  int tx_starts[$];

  bf_io_uart #(
    .CLK_HZ   (1000000),
    .BAUD     (100000),
    .TX_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_req     (io_req),
    .io_dir     (io_dir),
    .io_wdata   (io_wdata),
    .io_ack     (io_ack),
    .io_rdata   (io_rdata),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus transaction: hold io_req until io_ack or the cycle budget, then release.
  task automatic applyStimulus(input logic dir, input logic [7:0] wd, input int max_cyc,
                               output logic [7:0] rd, output int lat, output bit ok,
                               output logic ack_after);
    io_dir   = dir;
    io_wdata = wd;
    io_req   = 1'b1;
    lat = 0;
    ok  = 1'b0;
    rd  = 8'h00;
    while (!ok && lat < max_cyc) begin
      tick(1);
      lat++;
      if (io_ack === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      last_ack_cyc = cyc;
      rd = io_rdata;
      if (dir == DIRECTION_WRITE && mon_en) tx_exp.push_back(wd);
    end
    io_req = 1'b0;
    tick(1);
    ack_after = io_ack;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(10);
    end
    uart_rx = stop_bit;
    tick(10);
    uart_rx = 1'b1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (tx_frames < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("tx_frames_done", tx_frames, target);
  endtask

  // Serial decoder: samples each bit at its centre and pops the scoreboard.
  initial begin
    int k;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && uart_tx === 1'b0) begin
        k = cyc;
        tx_starts.push_back(k);
        repeat (5) @(negedge clk);
        checkOutput("tx_start_bit", {31'd0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (10) @(negedge clk);
        checkOutput("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
        checkOutput("tx_frame_expected", {31'd0, tx_exp.size() > 0}, 32'd1);
        if (tx_exp.size() > 0) checkOutput("tx_byte", {24'd0, b}, {24'd0, tx_exp.pop_front()});
        tx_frames++;
        repeat (4) @(negedge clk);
      end
    end
  end

  initial begin
    logic [7:0] rd;
    int lat;
    bit ok;
    logic ack_after;
    int base;
    int d;
    bit saw_low;

    // Reset
    rst_n = 1'b0;
    tick(3);
    checkOutput("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("rst_io_ack", {31'd0, io_ack}, 32'd0);
    checkOutput("rst_io_rdata", {24'd0, io_rdata}, 32'd0);
    checkOutput("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single write of 0x41
    base = tx_starts.size();
    applyStimulus(DIRECTION_WRITE, 8'h41, 20, rd, lat, ok, ack_after);
    checkOutput("wr41_ack", {31'd0, ok}, 32'd1);
    checkOutput("wr41_latency", lat, 1);
    checkOutput("wr41_ack_pulse", {31'd0, ack_after}, 32'd0);
    wait_frames(1, 200);
    if (tx_starts.size() > base)
      checkOutput("wr41_start_delay", tx_starts[base] - last_ack_cyc, 1);
    tick(20);

    // Burst of six writes: five accepted at once, the sixth stalls on a full FIFO
    base = tx_starts.size();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(DIRECTION_WRITE, 8'h30 + 8'(i), 20, rd, lat, ok, ack_after);
      checkOutput("burst_ack", {31'd0, ok}, 32'd1);
      checkOutput("burst_latency", lat, 1);
    end
    applyStimulus(DIRECTION_WRITE, 8'h35, 200, rd, lat, ok, ack_after);
    checkOutput("full_ack", {31'd0, ok}, 32'd1);
    checkOutput("full_stalled", {31'd0, lat >= 50 && lat <= 100}, 32'd1);
    wait_frames(7, 800);
    for (int i = 1; i < 6; i++) begin
      d = (tx_starts.size() > base + i) ? tx_starts[base + i] - tx_starts[base + i - 1] : -1;
      checkOutput("burst_contiguous", d, 100);
    end
    tick(20);

    // Read stalls on empty holding register until 0x5A arrives
    fork
      applyStimulus(DIRECTION_READ, 8'h00, 200, rd, lat, ok, ack_after);
      uart_send(8'h5A, 1'b1);
    join
    checkOutput("rd5a_ack", {31'd0, ok}, 32'd1);
    checkOutput("rd5a_after_stop", {31'd0, lat >= 90 && lat <= 110}, 32'd1);
    checkOutput("rd5a_data", {24'd0, rd}, 32'h5A);
    checkOutput("rd5a_no_overrun", {31'd0, rx_overrun}, 32'd0);
    tick(20);

    // Two bytes without a read: overrun, newest byte kept
    uart_send(8'h11, 1'b1);
    uart_send(8'h22, 1'b1);
    tick(5);
    checkOutput("overrun_set", {31'd0, rx_overrun}, 32'd1);
    applyStimulus(DIRECTION_READ, 8'h00, 20, rd, lat, ok, ack_after);
    checkOutput("overrun_rd_ack", {31'd0, ok}, 32'd1);
    checkOutput("overrun_rd_latency", lat, 1);
    checkOutput("overrun_rd_data", {24'd0, rd}, 32'h22);
    tick(20);

    // Glitch and framing error: neither produces a byte
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(30);
    uart_send(8'h77, 1'b0);
    tick(20);
    applyStimulus(DIRECTION_READ, 8'h00, 150, rd, lat, ok, ack_after);
    checkOutput("no_byte_no_ack", {31'd0, ok}, 32'd0);
    checkOutput("rdata_held", {24'd0, io_rdata}, 32'h22);
    checkOutput("overrun_sticky", {31'd0, rx_overrun}, 32'd1);
    fork
      applyStimulus(DIRECTION_READ, 8'h00, 200, rd, lat, ok, ack_after);
      uart_send(8'h3C, 1'b1);
    join
    checkOutput("recover_ack", {31'd0, ok}, 32'd1);
    checkOutput("recover_data", {24'd0, rd}, 32'h3C);
    tick(20);

    // Reset in mid-frame aborts the frame and flushes the FIFO
    mon_en = 1'b0;
    applyStimulus(DIRECTION_WRITE, 8'h00, 20, rd, lat, ok, ack_after);
    applyStimulus(DIRECTION_WRITE, 8'h00, 20, rd, lat, ok, ack_after);
    tick(30);
    checkOutput("midframe_low", {31'd0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    tick(1);
    checkOutput("midframe_rst_tx", {31'd0, uart_tx}, 32'd1);
    tick(2);
    checkOutput("midframe_rst_overrun", {31'd0, rx_overrun}, 32'd0);
    checkOutput("midframe_rst_rdata", {24'd0, io_rdata}, 32'd0);
    rst_n = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (uart_tx !== 1'b1) saw_low = 1'b1;
    end
    checkOutput("fifo_flushed", {31'd0, saw_low}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
